// File: rtl/cmp_search_pkg.sv
// Shared types for the comparator search controller: FSM states and the {lt,eq,gt} flag vector.
// Types only; no timing or flow-control behaviour.
package cmp_search_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit order is {lt, eq, gt}
    typedef logic [2:0] flags_t;

    localparam flags_t FLAG_LT = 3'b100;
    localparam flags_t FLAG_EQ = 3'b010;
    localparam flags_t FLAG_GT = 3'b001;

endpackage

// File: rtl/cmp_flag_check.sv
// Decodes comparator flags into one-hot results plus a "not exactly one-hot" error.
// Purely combinational, zero latency; no flow control.
module cmp_flag_check
    import cmp_search_pkg::*;
(
    input  flags_t i_flags,
    output logic   o_is_lt,
    output logic   o_is_eq,
    output logic   o_is_gt,
    output logic   o_bad
);

    always_comb begin
        o_is_lt = (i_flags == FLAG_LT);
        o_is_eq = (i_flags == FLAG_EQ);
        o_is_gt = (i_flags == FLAG_GT);
        o_bad   = !(o_is_lt || o_is_eq || o_is_gt);
    end

endmodule

// File: rtl/cmp_search_ctrl.sv
// Binary search for a target on the comparator B side, one registered probe per cycle.
// Latency start->done = steps+1 cycles; start is accepted only in IDLE, otherwise ignored.
module cmp_search_ctrl
    import cmp_search_pkg::*;
#(
    parameter  int WIDTH = 3,
    localparam int STEPW = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             lt,
    input  logic             eq,
    input  logic             gt,
    output logic [WIDTH-1:0] probe,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic [STEPW-1:0] steps
);

    localparam logic [WIDTH:0]   MAXV   = (WIDTH+1)'(2**WIDTH - 1);
    localparam logic [WIDTH-1:0] PROBE0 = WIDTH'((2**WIDTH - 1) / 2);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH:0]   r_lo;
    logic [WIDTH:0]   r_hi;
    logic [WIDTH:0]   w_lo_nxt;
    logic [WIDTH:0]   w_hi_nxt;
    logic [WIDTH-1:0] r_probe;
    logic [WIDTH-1:0] w_probe_nxt;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] w_result_nxt;
    logic [STEPW-1:0] r_steps;
    logic [STEPW-1:0] w_steps_nxt;
    logic             r_found;
    logic             w_found_nxt;
    logic             r_err;
    logic             w_err_nxt;

    logic             w_is_lt;
    logic             w_is_eq;
    logic             w_is_gt;
    logic             w_bad;
    logic [WIDTH:0]   w_probe_x;
    logic [WIDTH:0]   w_lo_new;
    logic [WIDTH:0]   w_hi_new;
    logic [WIDTH+1:0] w_sum;
    logic             w_empty;
    logic             w_unused;

    cmp_flag_check u_flag_check (
        .i_flags (flags_t'({lt, eq, gt})),
        .o_is_lt (w_is_lt),
        .o_is_eq (w_is_eq),
        .o_is_gt (w_is_gt),
        .o_bad   (w_bad)
    );

    // The range empties exactly when the probe sits on the bound being moved past,
    // so the -1 at probe=0 is never taken and lo/hi never wrap.
    always_comb begin
        w_probe_x = {1'b0, r_probe};
        w_lo_new  = r_lo;
        w_hi_new  = r_hi;
        w_empty   = (w_is_gt && (w_probe_x == r_lo)) || (w_is_lt && (w_probe_x == r_hi));
        if (w_is_gt && !w_empty) begin
            w_hi_new = w_probe_x - 1'b1;
        end
        if (w_is_lt && !w_empty) begin
            w_lo_new = w_probe_x + 1'b1;
        end
        w_sum = {1'b0, w_lo_new} + {1'b0, w_hi_new};
    end

    assign w_unused = ^{w_sum[WIDTH+1], w_sum[0]};

    always_comb begin
        w_state_nxt  = r_state;
        w_lo_nxt     = r_lo;
        w_hi_nxt     = r_hi;
        w_probe_nxt  = r_probe;
        w_steps_nxt  = r_steps;
        w_found_nxt  = r_found;
        w_err_nxt    = r_err;
        w_result_nxt = r_result;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_lo_nxt     = '0;
                    w_hi_nxt     = MAXV;
                    w_probe_nxt  = PROBE0;
                    w_steps_nxt  = '0;
                    w_found_nxt  = 1'b0;
                    w_err_nxt    = 1'b0;
                    w_result_nxt = '0;
                    w_state_nxt  = CMP;
                end
            end
            CMP: begin
                w_steps_nxt = r_steps + STEPW'(1);
                if (w_bad) begin
                    w_err_nxt    = 1'b1;
                    w_found_nxt  = 1'b0;
                    w_result_nxt = '0;
                    w_state_nxt  = DONE;
                end else if (w_is_eq) begin
                    w_found_nxt  = 1'b1;
                    w_result_nxt = r_probe;
                    w_state_nxt  = DONE;
                end else if (w_empty) begin
                    w_found_nxt  = 1'b0;
                    w_result_nxt = '0;
                    w_state_nxt  = DONE;
                end else begin
                    w_lo_nxt    = w_lo_new;
                    w_hi_nxt    = w_hi_new;
                    w_probe_nxt = w_sum[WIDTH:1];
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_lo     <= '0;
            r_hi     <= '0;
            r_probe  <= '0;
            r_steps  <= '0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_lo     <= w_lo_nxt;
            r_hi     <= w_hi_nxt;
            r_probe  <= w_probe_nxt;
            r_steps  <= w_steps_nxt;
            r_found  <= w_found_nxt;
            r_err    <= w_err_nxt;
            r_result <= w_result_nxt;
        end
    end

    assign probe  = r_probe;
    assign busy   = (r_state == CMP);
    assign done   = (r_state == DONE);
    assign found  = r_found;
    assign err    = r_err;
    assign result = r_result;
    assign steps  = r_steps;

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Directed bench for cmp_search_ctrl with a behavioural 3-bit comparator on the flag inputs
// and a flag-forcing mode for the not-found and malformed-flag cases.
module tb_cmp_search_ctrl;
    import cmp_search_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       lt, eq, gt;
    logic [2:0] probe;
    logic       busy, done, found, err;
    logic [2:0] result;
    logic [2:0] steps;

    logic [2:0] target;
    int         force_mode;
    int         checks = 0;
    int         errors = 0;

    logic [2:0] seen [16];
    int         nseen;
    int         lat;
    logic       got_done;

    always #5 clk = ~clk;

    // 0: comparator B=target, cascade l=0,e=1,g=0; 1: gt stuck; 2: flags 000; 3: flags 011
    always_comb begin
        lt = 1'b0;
        eq = 1'b0;
        gt = 1'b0;
        case (force_mode)
            1: gt = 1'b1;
            2: ;
            3: begin eq = 1'b1; gt = 1'b1; end
            default: begin
                lt = (probe < target);
                eq = (probe == target);
                gt = (probe > target);
            end
        endcase
    end

    cmp_search_ctrl #(.WIDTH(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .lt     (lt),
        .eq     (eq),
        .gt     (gt),
        .probe  (probe),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .err    (err),
        .result (result),
        .steps  (steps)
    );

    // Collects probes after an accepted start until done or budget expiry.
    task automatic wait_done();
        nseen    = 0;
        lat      = 1;
        got_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy && nseen < 16) begin
                seen[nseen] = probe;
                nseen++;
            end
            @(negedge clk);
            lat++;
        end
        checks++;
        if (!got_done) begin
            errors++;
            $display("FAIL done_timeout: no done within 12 cycles");
        end
    endtask

    task automatic run_search(input int mode, input logic [2:0] tgt, input int n,
                              input logic [2:0] p0, input logic [2:0] p1,
                              input logic [2:0] p2, input logic [2:0] p3,
                              input logic ef, input logic ee, input logic [2:0] eres);
        logic [2:0] e [4];
        e = '{p0, p1, p2, p3};
        force_mode = mode;
        target     = tgt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done();
        checks++;
        if (nseen !== n) begin errors++; $display("FAIL nprobes tgt=%0d got %0d exp %0d", tgt, nseen, n); end
        for (int i = 0; i < n && i < nseen; i++) begin
            checks++;
            if (seen[i] !== e[i]) begin errors++; $display("FAIL probe[%0d] tgt=%0d got %0d exp %0d", i, tgt, seen[i], e[i]); end
        end
        checks++;
        if (found !== ef) begin errors++; $display("FAIL found tgt=%0d got %0b exp %0b", tgt, found, ef); end
        checks++;
        if (err !== ee) begin errors++; $display("FAIL err tgt=%0d got %0b exp %0b", tgt, err, ee); end
        checks++;
        if (result !== eres) begin errors++; $display("FAIL result tgt=%0d got %0d exp %0d", tgt, result, eres); end
        checks++;
        if (steps !== 3'(n)) begin errors++; $display("FAIL steps tgt=%0d got %0d exp %0d", tgt, steps, n); end
        checks++;
        if (lat !== n + 1) begin errors++; $display("FAIL latency tgt=%0d got %0d exp %0d", tgt, lat, n + 1); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done got %0b exp 0", busy); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %0b exp 0", done); end
        checks++;
        if (result !== eres || steps !== 3'(n)) begin
            errors++;
            $display("FAIL hold got result=%0d steps=%0d exp %0d %0d", result, steps, eres, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; target = 3'd0; force_mode = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({probe, busy, done, found, err, result, steps} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0", {probe, busy, done, found, err, result, steps});
        end
        checks++;
        if (dut.r_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dut.r_state, IDLE); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_no_start got busy=%0b done=%0b exp 0 0", busy, done); end
    endtask

    task automatic test_hit();
        run_search(0, 3'd5, 2, 3'd3, 3'd5, 3'd0, 3'd0, 1'b1, 1'b0, 3'd5);
    endtask

    task automatic test_edges();
        run_search(0, 3'd0, 3, 3'd3, 3'd1, 3'd0, 3'd0, 1'b1, 1'b0, 3'd0);
        run_search(0, 3'd7, 4, 3'd3, 3'd5, 3'd6, 3'd7, 1'b1, 1'b0, 3'd7);
    endtask

    task automatic test_not_found();
        run_search(1, 3'd0, 3, 3'd3, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic test_bad_flags();
        run_search(2, 3'd0, 1, 3'd3, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 3'd0);
        run_search(3, 3'd0, 1, 3'd3, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 3'd0);
    endtask

    // start held high through CMP and DONE; leaves start high into the following IDLE cycle.
    task automatic test_start_ignored();
        force_mode = 0;
        target     = 3'd5;
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        checks++;
        if (probe !== 3'd3 || busy !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL accept got probe=%0d busy=%0b err=%0b exp 3 1 0", probe, busy, err);
        end
        @(negedge clk);
        checks++;
        if (probe !== 3'd5 || steps !== 3'd1) begin
            errors++;
            $display("FAIL start_in_cmp got probe=%0d steps=%0d exp 5 1", probe, steps);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || found !== 1'b1 || result !== 3'd5 || steps !== 3'd2) begin
            errors++;
            $display("FAIL done_with_start got done=%0b found=%0b result=%0d steps=%0d exp 1 1 5 2", done, found, result, steps);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || found !== 1'b1 || result !== 3'd5 || steps !== 3'd2) begin
            errors++;
            $display("FAIL start_in_done got busy=%0b done=%0b found=%0b result=%0d steps=%0d exp 0 0 1 5 2", busy, done, found, result, steps);
        end
    endtask

    task automatic test_back_to_back();
        target = 3'd2;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || probe !== 3'd3 || found !== 1'b0 || result !== 3'd0 || steps !== 3'd0) begin
            errors++;
            $display("FAIL b2b_clear got busy=%0b probe=%0d found=%0b result=%0d steps=%0d exp 1 3 0 0 0", busy, probe, found, result, steps);
        end
        wait_done();
        checks++;
        if (nseen !== 3 || seen[0] !== 3'd3 || seen[1] !== 3'd1 || seen[2] !== 3'd2) begin
            errors++;
            $display("FAIL b2b_probes got n=%0d %0d,%0d,%0d exp 3 3,1,2", nseen, seen[0], seen[1], seen[2]);
        end
        checks++;
        if (found !== 1'b1 || result !== 3'd2 || steps !== 3'd3) begin
            errors++;
            $display("FAIL b2b_result got found=%0b result=%0d steps=%0d exp 1 2 3", found, result, steps);
        end
        @(negedge clk);
    endtask

    task automatic test_rst_mid();
        logic saw_done;
        force_mode = 0;
        target     = 3'd7;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk);
        checks++;
        if (probe !== 3'd5 || busy !== 1'b1 || steps !== 3'd1) begin
            errors++;
            $display("FAIL rst_setup got probe=%0d busy=%0b steps=%0d exp 5 1 1", probe, busy, steps);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({probe, busy, done, found, err, result, steps} !== 13'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs got %b exp 0", {probe, busy, done, found, err, result, steps});
        end
        checks++;
        if (dut.r_state !== IDLE) begin errors++; $display("FAIL rst_mid_state got %0d exp %0d", dut.r_state, IDLE); end
        saw_done = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin errors++; $display("FAIL rst_no_done got activity=1 exp 0"); end
        run_search(0, 3'd7, 4, 3'd3, 3'd5, 3'd6, 3'd7, 1'b1, 1'b0, 3'd7);
    endtask

    initial begin
        test_reset();
        test_hit();
        test_edges();
        test_not_found();
        test_bad_flags();
        test_start_ignored();
        test_back_to_back();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
